fpu_add_sub_result: RTL and testbench

FPU_ADD_SUB_RESULT -- requirements
Module: fpu_add_sub_result

---
 rtl/fpu_add_sub_result.sv | 69 ++++++
 tb/tb_fpu_add_sub_result.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fpu_add_sub_result.sv
// fpu_add_sub_result: FP add/sub result select, NaN canonicalise, 2-entry result FIFO to writeback, sticky fflags accrue on retire.
module fpu_add_sub_result #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000,
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        mux_fastres_sel_i,
  input  logic [31:0] fast_res_i,
  input  logic        overflow_fast_i,
  input  logic        invalid_fast_i,
  input  logic [31:0] slow_res_i,
  input  logic [4:0]  slow_flags_i,
  input  logic [4:0]  rd_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_res_o,
  output logic [4:0]  out_flags_o,
  output logic [4:0]  out_rd_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_wr_i,
  input  logic [4:0]  fflags_wdata_i,
  input  logic        flush_i
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [41:0]   mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [4:0]    fflags, flags;
  logic [31:0]   res_sel, res;
  logic          push, pop;
  always_comb begin
    res_sel = mux_fastres_sel_i ? fast_res_i : slow_res_i;
    flags   = mux_fastres_sel_i ? {invalid_fast_i, 1'b0, overflow_fast_i, 1'b0, overflow_fast_i} : slow_flags_i;
    res     = (res_sel[30:23] == 8'hFF && res_sel[22:0] != '0) ? CANON_NAN : res_sel;
  end
  assign in_ready_o  = count < FULL;
  assign out_valid_o = count != '0;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;
  assign {out_res_o, out_flags_o, out_rd_o} = mem[head];
  assign fflags_o    = fflags;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      fflags <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush_i) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) mem[tail] <= {res, flags, rd_i};
        if (push) tail <= tail == LAST ? '0 : tail + PW'(1);
        if (pop) head <= head == LAST ? '0 : head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      fflags <= fflags_wr_i ? fflags_wdata_i | (pop ? out_flags_o : 5'b0) : pop ? fflags | out_flags_o : fflags;
    end
  end
endmodule

// File: tb/tb_fpu_add_sub_result.sv
// tb_fpu_add_sub_result: directed self-checking bench for the add/sub result buffer.
module tb_fpu_add_sub_result;
  logic        clk_i = 0, reset_i = 0;
  logic        in_valid_i = 0, in_ready_o;
  logic        mux_fastres_sel_i = 0;
  logic [31:0] fast_res_i = 0, slow_res_i = 0;
  logic        overflow_fast_i = 0, invalid_fast_i = 0;
  logic [4:0]  slow_flags_i = 0, rd_i = 0;
  logic        out_valid_o, out_ready_i = 0;
  logic [31:0] out_res_o;
  logic [4:0]  out_flags_o, out_rd_o, fflags_o;
  logic        fflags_wr_i = 0, flush_i = 0;
  logic [4:0]  fflags_wdata_i = 0;
  int n_cmp = 0, n_err = 0;

  fpu_add_sub_result dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mux_fastres_sel_i(mux_fastres_sel_i), .fast_res_i(fast_res_i),
    .overflow_fast_i(overflow_fast_i), .invalid_fast_i(invalid_fast_i),
    .slow_res_i(slow_res_i), .slow_flags_i(slow_flags_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_res_o(out_res_o),
    .out_flags_o(out_flags_o), .out_rd_o(out_rd_o), .fflags_o(fflags_o),
    .fflags_wr_i(fflags_wr_i), .fflags_wdata_i(fflags_wdata_i), .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic slow_in(input logic [31:0] r, input logic [4:0] f, input logic [4:0] d);
    mux_fastres_sel_i = 0;
    slow_res_i = r;
    slow_flags_i = f;
    rd_i = d;
    in_valid_i = 1;
  endtask

  task automatic test_reset;
    reset_i = 0;
    step; step;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
    n_cmp++; if ({out_res_o, out_flags_o, out_rd_o} !== 42'h0) begin n_err++; $display("FAIL reset_out got %h want 0", {out_res_o, out_flags_o, out_rd_o}); end
    n_cmp++; if (fflags_o !== 5'b0) begin n_err++; $display("FAIL reset_fflags got %b want 00000", fflags_o); end
    reset_i = 1;
    step;
  endtask

  task automatic test_fast_path;
    mux_fastres_sel_i = 1;
    fast_res_i = 32'h7F800000;
    overflow_fast_i = 1;
    invalid_fast_i = 0;
    rd_i = 3;
    in_valid_i = 1;
    out_ready_i = 1;
    step;
    in_valid_i = 0;
    overflow_fast_i = 0;
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL fast_valid got %b want 1", out_valid_o); end
    n_cmp++; if (out_res_o !== 32'h7F800000) begin n_err++; $display("FAIL fast_res got %h want 7f800000", out_res_o); end
    n_cmp++; if (out_flags_o !== 5'b00101) begin n_err++; $display("FAIL fast_flags got %b want 00101", out_flags_o); end
    n_cmp++; if (out_rd_o !== 5'd3) begin n_err++; $display("FAIL fast_rd got %0d want 3", out_rd_o); end
    n_cmp++; if (fflags_o !== 5'b0) begin n_err++; $display("FAIL fast_fflags_pre got %b want 00000", fflags_o); end
    step;
    n_cmp++; if (fflags_o !== 5'b00101) begin n_err++; $display("FAIL fast_fflags got %b want 00101", fflags_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL fast_empty got %b want 0", out_valid_o); end
    out_ready_i = 0;
  endtask

  task automatic test_nan_canon;
    slow_in(32'h7F800001, 5'b10000, 5'd5);
    step;
    in_valid_i = 0;
    n_cmp++; if (out_res_o !== 32'h7FC00000) begin n_err++; $display("FAIL nan_res got %h want 7fc00000", out_res_o); end
    n_cmp++; if (out_flags_o !== 5'b10000) begin n_err++; $display("FAIL nan_flags got %b want 10000", out_flags_o); end
    step;
    n_cmp++; if ({out_valid_o, out_res_o, out_rd_o} !== {1'b1, 32'h7FC00000, 5'd5}) begin n_err++; $display("FAIL nan_hold got %b/%h/%0d want 1/7fc00000/5", out_valid_o, out_res_o, out_rd_o); end
    out_ready_i = 1;
    step;
    out_ready_i = 0;
    n_cmp++; if (fflags_o !== 5'b10101) begin n_err++; $display("FAIL nan_fflags got %b want 10101", fflags_o); end
  endtask

  task automatic test_back_to_back;
    slow_in(32'h3F800000, 5'b00000, 5'd1);
    step;
    n_cmp++; if ({out_valid_o, out_rd_o, in_ready_o} !== {1'b1, 5'd1, 1'b1}) begin n_err++; $display("FAIL b2b_a got v%b rd%0d rdy%b want v1 rd1 rdy1", out_valid_o, out_rd_o, in_ready_o); end
    slow_in(32'hFF800001, 5'b00001, 5'd2);
    step;
    n_cmp++; if ({in_ready_o, out_rd_o, out_res_o} !== {1'b0, 5'd1, 32'h3F800000}) begin n_err++; $display("FAIL b2b_full got rdy%b rd%0d %h want rdy0 rd1 3f800000", in_ready_o, out_rd_o, out_res_o); end
    slow_in(32'h40000000, 5'b00000, 5'd4);
    step;
    n_cmp++; if ({in_ready_o, out_rd_o} !== {1'b0, 5'd1}) begin n_err++; $display("FAIL b2b_c_held got rdy%b rd%0d want rdy0 rd1", in_ready_o, out_rd_o); end
    out_ready_i = 1;
    step;
    n_cmp++; if ({out_rd_o, out_res_o, out_flags_o, in_ready_o} !== {5'd2, 32'h7FC00000, 5'b00001, 1'b1}) begin n_err++; $display("FAIL b2b_b got rd%0d %h %b rdy%b want rd2 7fc00000 00001 rdy1", out_rd_o, out_res_o, out_flags_o, in_ready_o); end
    step;
    in_valid_i = 0;
    n_cmp++; if ({out_valid_o, out_rd_o, out_res_o} !== {1'b1, 5'd4, 32'h40000000}) begin n_err++; $display("FAIL b2b_c got v%b rd%0d %h want v1 rd4 40000000", out_valid_o, out_rd_o, out_res_o); end
    step;
    out_ready_i = 0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid_o); end
    n_cmp++; if (fflags_o !== 5'b10101) begin n_err++; $display("FAIL b2b_fflags got %b want 10101", fflags_o); end
  endtask

  task automatic test_csr_write;
    fflags_wr_i = 1;
    fflags_wdata_i = 5'b00001;
    step;
    n_cmp++; if (fflags_o !== 5'b00001) begin n_err++; $display("FAIL csr_wr got %b want 00001", fflags_o); end
    fflags_wr_i = 0;
    slow_in(32'h3F800000, 5'b10000, 5'd7);
    step;
    in_valid_i = 0;
    fflags_wr_i = 1;
    fflags_wdata_i = 5'b00000;
    out_ready_i = 1;
    step;
    fflags_wr_i = 0;
    out_ready_i = 0;
    n_cmp++; if (fflags_o !== 5'b10000) begin n_err++; $display("FAIL csr_pop got %b want 10000", fflags_o); end
  endtask

  task automatic test_flush;
    slow_in(32'h3F800000, 5'b01000, 5'd8);
    step;
    slow_in(32'h3F800000, 5'b01000, 5'd9);
    step;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_pre_full got %b want 0", in_ready_o); end
    flush_i = 1;
    out_ready_i = 1;
    step;
    flush_i = 0;
    in_valid_i = 0;
    out_ready_i = 0;
    n_cmp++; if ({out_valid_o, in_ready_o} !== 2'b01) begin n_err++; $display("FAIL flush_state got v%b rdy%b want v0 rdy1", out_valid_o, in_ready_o); end
    n_cmp++; if (fflags_o !== 5'b10000) begin n_err++; $display("FAIL flush_fflags got %b want 10000", fflags_o); end
  endtask

  task automatic test_async_reset;
    slow_in(32'h3F800000, 5'b00100, 5'd6);
    step;
    in_valid_i = 0;
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL areset_pre got %b want 1", out_valid_o); end
    #2 reset_i = 0;
    #1;
    n_cmp++; if ({out_valid_o, in_ready_o, fflags_o} !== {1'b0, 1'b1, 5'b0}) begin n_err++; $display("FAIL areset_now got v%b rdy%b ff%b want v0 rdy1 ff00000", out_valid_o, in_ready_o, fflags_o); end
    n_cmp++; if ({out_res_o, out_rd_o} !== 37'h0) begin n_err++; $display("FAIL areset_out got %h/%0d want 0/0", out_res_o, out_rd_o); end
    #2 reset_i = 1;
    step;
    n_cmp++; if ({out_valid_o, fflags_o} !== 6'b0) begin n_err++; $display("FAIL areset_after got v%b ff%b want v0 ff00000", out_valid_o, fflags_o); end
  endtask

  initial begin
    test_reset;
    test_fast_path;
    test_nan_canon;
    test_back_to_back;
    test_csr_write;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
